mm_transpose_tile: RTL and testbench

- Memory-mapped peripheral on the openMSP430 peripheral bus. Its per_dout is OR-ed into the CPU per_dout mux, alongside gpio, timerA, uart and transpose_support.
- Buffers a DIM x DIM tile of 16-bit words written row-major by software, transposes it in place in hardware, then streams it back through a single data register.
- Feeds and offloads the software transpose routine: the CPU streams tiles in and out instead of doing indexed swaps.

---
 rtl/mm_transpose_tile.sv | 210 +++++++++++++++++++++
 tb/tb_mm_transpose_tile.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mm_transpose_tile.sv
`default_nettype none
// ============================================================================
// Module      : mm_transpose_tile
// Description : openMSP430 peripheral that buffers a DIM x DIM tile of 16-bit
//               words, transposes it in place and streams it back out.
// Revision    : 1.0
// ============================================================================
module mm_transpose_tile #(
    parameter logic [14:0] BASE_ADDR = 15'h0190,
    parameter int          DIM       = 4
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout
);

    localparam int c_N     = DIM * DIM;
    localparam int c_CNT_W = $clog2(c_N) + 1;
    localparam int c_IDX_W = c_CNT_W - 1;
    localparam int c_IW    = (DIM <= 2) ? 1 : $clog2(DIM);

    localparam logic [1:0] c_REG_CTRL = 2'd0;
    localparam logic [1:0] c_REG_DIN  = 2'd1;
    localparam logic [1:0] c_REG_DOUT = 2'd2;
    localparam logic [1:0] c_REG_INFO = 2'd3;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_SWAP  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_mem [c_N];
    logic [c_CNT_W-1:0]   r_wr_cnt;
    logic [c_CNT_W-1:0]   r_rd_cnt;
    logic [c_IW-1:0]      r_si;
    logic [c_IW-1:0]      r_sj;
    logic                 r_done;
    logic                 r_ovf;
    logic                 r_err;

    logic                 w_sel;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_clr;
    logic                 w_go;
    logic                 w_din_wr;
    logic                 w_dout_rd;
    logic                 w_full;
    logic                 w_busy;
    logic                 w_swap_last;
    logic                 w_drain_last;
    logic [c_IDX_W-1:0]   w_swap_a;
    logic [c_IDX_W-1:0]   w_swap_b;
    logic [15:0]          w_status;
    logic [7:0]           w_count;

    // Bus decode: only full-word writes act, reads are per_we == 0
    assign w_sel     = per_en && (per_addr[13:2] == BASE_ADDR[14:3]);
    assign w_wr      = w_sel && (per_we == 2'b11);
    assign w_rd      = w_sel && (per_we == 2'b00);
    assign w_clr     = w_wr && (per_addr[1:0] == c_REG_CTRL) && per_din[0];
    assign w_go      = w_wr && (per_addr[1:0] == c_REG_CTRL) && per_din[1];
    assign w_din_wr  = w_wr && (per_addr[1:0] == c_REG_DIN);
    assign w_dout_rd = w_rd && (per_addr[1:0] == c_REG_DOUT);

    assign w_full       = (r_state == S_FILL) && (r_wr_cnt == c_CNT_W'(c_N));
    assign w_busy       = (r_state == S_SWAP);
    assign w_swap_last  = (r_si == c_IW'(DIM - 2)) && (r_sj == c_IW'(DIM - 1));
    assign w_drain_last = (r_rd_cnt == c_CNT_W'(c_N - 1));

    // Mirror positions of the current upper-triangle pair (i,j) and (j,i)
    assign w_swap_a = c_IDX_W'(int'(r_si) * DIM + int'(r_sj));
    assign w_swap_b = c_IDX_W'(int'(r_sj) * DIM + int'(r_si));

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL:  if (w_go && w_full) w_state_nxt = S_SWAP;
                S_SWAP:  if (w_swap_last) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_dout_rd && w_drain_last) w_state_nxt = S_FILL;
                default: w_state_nxt = S_FILL;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_si     <= '0;
            r_sj     <= c_IW'(1);
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_clr) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_si     <= '0;
            r_sj     <= c_IW'(1);
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_din_wr) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + c_CNT_W'(1);
                        end
                    end
                    if (w_go && !w_full) begin
                        r_err <= 1'b1;
                    end
                    if (w_go && w_full) begin
                        r_si <= '0;
                        r_sj <= c_IW'(1);
                    end
                end
                S_SWAP: begin
                    if (w_din_wr) r_ovf <= 1'b1;
                    if (w_go)     r_err <= 1'b1;
                    if (r_sj == c_IW'(DIM - 1)) begin
                        r_si <= r_si + c_IW'(1);
                        r_sj <= r_si + c_IW'(2);
                    end else begin
                        r_sj <= r_sj + c_IW'(1);
                    end
                    if (w_swap_last) r_done <= 1'b1;
                end
                S_DRAIN: begin
                    if (w_din_wr) r_ovf <= 1'b1;
                    if (w_go)     r_err <= 1'b1;
                    if (w_dout_rd) begin
                        if (w_drain_last) begin
                            r_rd_cnt <= '0;
                            r_wr_cnt <= '0;
                            r_done   <= 1'b0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_wr_cnt <= '0;
                    r_rd_cnt <= '0;
                end
            endcase
        end
    end

    // Tile storage is deliberately left uncleared by reset and CLR
    always_ff @(posedge mclk) begin
        if (reset_n && !w_clr) begin
            if ((r_state == S_FILL) && w_din_wr && !w_full) begin
                r_mem[r_wr_cnt[c_IDX_W-1:0]] <= per_din;
            end
            if (r_state == S_SWAP) begin
                r_mem[w_swap_a] <= r_mem[w_swap_b];
                r_mem[w_swap_b] <= r_mem[w_swap_a];
            end
        end
    end

    assign w_status = {11'd0, r_err, r_ovf, r_done, w_busy, w_full};

    always_comb begin
        w_count = 8'(r_wr_cnt);
        if (r_state == S_DRAIN) begin
            w_count = 8'(c_N) - 8'(r_rd_cnt);
        end
    end

    always_comb begin
        per_dout = 16'h0000;
        if (w_rd) begin
            case (per_addr[1:0])
                c_REG_CTRL: per_dout = w_status;
                c_REG_DOUT: begin
                    if (r_state == S_DRAIN) begin
                        per_dout = r_mem[r_rd_cnt[c_IDX_W-1:0]];
                    end
                end
                c_REG_INFO: per_dout = {8'(DIM), w_count};
                default:    per_dout = 16'h0000;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mm_transpose_tile.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_transpose_tile
// Description : Directed self-checking bench for mm_transpose_tile.
// Revision    : 1.0
// ============================================================================
module tb_mm_transpose_tile;

    localparam logic [13:0] c_BASE_W = 14'h00C8;
    localparam logic [1:0]  c_CTRL   = 2'd0;
    localparam logic [1:0]  c_DIN    = 2'd1;
    localparam logic [1:0]  c_DOUT   = 2'd2;
    localparam logic [1:0]  c_INFO   = 2'd3;

    logic        clk;
    logic        reset_n;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    int n_checks;
    int n_fail;

    mm_transpose_tile #(
        .BASE_ADDR(15'h0190),
        .DIM      (4)
    ) u_dut (
        .mclk    (clk),
        .reset_n (reset_n),
        .per_addr(per_addr),
        .per_din (per_din),
        .per_en  (per_en),
        .per_we  (per_we),
        .per_dout(per_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [13:0] addr, input logic [1:0] we,
                          input logic en, input logic [15:0] d);
        @(negedge clk);
        per_en   = en;
        per_addr = addr;
        per_we   = we;
        per_din  = d;
        @(posedge clk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic wr(input logic [1:0] r, input logic [15:0] d);
        bus_wr({c_BASE_W[13:2], r}, 2'b11, 1'b1, d);
    endtask

    task automatic rd_addr(input logic [13:0] addr, output logic [15:0] d);
        @(negedge clk);
        per_en   = 1'b1;
        per_addr = addr;
        per_we   = 2'b00;
        #1;
        d = per_dout;
        @(posedge clk);
        #1;
        per_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, output logic [15:0] d);
        rd_addr({c_BASE_W[13:2], r}, d);
    endtask

    task automatic fill_tile(input logic [15:0] base);
        for (int k = 0; k < 16; k++) wr(c_DIN, base + 16'(k));
    endtask

    // Poll STATUS until DONE, returning how many BUSY reads were seen
    task automatic wait_done(output int busy_seen, output logic [15:0] last);
        logic [15:0] s;
        busy_seen = 0;
        last      = 16'h0;
        for (int n = 0; n < 50; n++) begin
            rd(c_CTRL, s);
            last = s;
            if (s[1]) busy_seen++;
            if (s[2]) break;
        end
        check("wait_done_timeout", {15'd0, last[2]}, 16'h0001);
    endtask

    task automatic drain_check(input logic [15:0] base, input int count, input string tag);
        logic [15:0] d;
        for (int k = 0; k < count; k++) begin
            rd(c_DOUT, d);
            check(tag, d, base + 16'((k % 4) * 4 + k / 4));
        end
    endtask

    initial begin
        logic [15:0] d;
        int          busy;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        per_en   = 1'b0;
        per_addr = '0;
        per_we   = 2'b00;
        per_din  = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rd(c_CTRL, d); check("rst_status", d, 16'h0000);
        rd(c_INFO, d); check("rst_info", d, 16'h0400);
        rd(c_DOUT, d); check("rst_dout", d, 16'h0000);
        rd_addr(14'h0100, d); check("rst_unsel", d, 16'h0000);

        // Basic transpose
        fill_tile(16'h0000);
        rd(c_CTRL, d); check("full_status", d, 16'h0001);
        rd(c_INFO, d); check("full_info", d, 16'h0410);
        wr(c_CTRL, 16'h0002);
        wait_done(busy, d);
        check("busy_cycles", 16'(busy), 16'd6);
        check("done_status", d, 16'h0004);
        rd(c_INFO, d); check("drain_info", d, 16'h0410);
        drain_check(16'h0000, 16, "xpose_a");
        rd(c_CTRL, d); check("post_status", d, 16'h0000);
        rd(c_INFO, d); check("post_info", d, 16'h0400);

        // Overflow and error
        fill_tile(16'h0000);
        wr(c_DIN, 16'hFFFF);
        rd(c_CTRL, d); check("ovf_status", d, 16'h0009);
        wr(c_CTRL, 16'h0001);
        for (int k = 0; k < 3; k++) wr(c_DIN, 16'(k));
        wr(c_CTRL, 16'h0002);
        rd(c_CTRL, d); check("err_status", d, 16'h0010);
        rd(c_INFO, d); check("err_info", d, 16'h0403);

        // Bus rules
        wr(c_CTRL, 16'h0001);
        wr(c_DIN, 16'h1111);
        wr(c_DIN, 16'h2222);
        bus_wr({c_BASE_W[13:2], c_DIN}, 2'b01, 1'b1, 16'h3333);
        rd(c_INFO, d); check("bytewr_info", d, 16'h0402);
        rd_addr(c_BASE_W + 14'd4, d); check("outside_rd", d, 16'h0000);
        bus_wr({c_BASE_W[13:2], c_DIN}, 2'b11, 1'b0, 16'h4444);
        rd(c_INFO, d); check("noen_info", d, 16'h0402);
        bus_wr({c_BASE_W[13:2], c_CTRL}, 2'b11, 1'b0, 16'h0001);
        rd(c_INFO, d); check("noen_clr_info", d, 16'h0402);

        // CLR mid-SWAP
        wr(c_CTRL, 16'h0001);
        fill_tile(16'h0000);
        wr(c_CTRL, 16'h0002);
        @(posedge clk);
        wr(c_CTRL, 16'h0001);
        rd(c_CTRL, d); check("clr_swap_status", d, 16'h0000);
        rd(c_INFO, d); check("clr_swap_info", d, 16'h0400);
        fill_tile(16'h0100);
        wr(c_CTRL, 16'h0002);
        wait_done(busy, d);
        check("busy_cycles_b", 16'(busy), 16'd6);
        drain_check(16'h0100, 16, "xpose_b");

        // CLR|GO together
        fill_tile(16'h0200);
        wr(c_CTRL, 16'h0003);
        rd(c_CTRL, d); check("clrgo_status", d, 16'h0000);
        rd(c_INFO, d); check("clrgo_info", d, 16'h0400);

        // Reset mid-DRAIN
        fill_tile(16'h0300);
        wr(c_CTRL, 16'h0002);
        wait_done(busy, d);
        drain_check(16'h0300, 5, "xpose_c");
        rd(c_INFO, d); check("drain5_info", d, 16'h040B);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        rd(c_CTRL, d); check("rst_drain_status", d, 16'h0000);
        rd(c_INFO, d); check("rst_drain_info", d, 16'h0400);
        rd(c_DOUT, d); check("rst_drain_dout", d, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
